// File: rtl/cpu_wb_pkg.sv
// cpu_wb_pkg: shared types for the CPU-side Wishbone master bridge.
//   wb_state_t : bridge FSM states (IDLE / BUS / HOLD)
//   wb_req_t   : latched CPU request (we, addr, wdata, sel, last), sized to the
//                widest supported bus; each bridge uses only the low AW/DW/SEL_W
//                bits and the rest stay zero.
//   cnt_width  : width needed by a counter that must be able to hold `limit`.
package cpu_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } wb_state_t;

  localparam int unsigned REQ_AW_MAX  = 64;
  localparam int unsigned REQ_DW_MAX  = 256;
  localparam int unsigned REQ_SEL_MAX = REQ_DW_MAX / 8;

  typedef struct packed {
    logic                   we;
    logic [REQ_AW_MAX-1:0]  addr;
    logic [REQ_DW_MAX-1:0]  wdata;
    logic [REQ_SEL_MAX-1:0] sel;
    logic                   last;
  } wb_req_t;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: stall timer for one Wishbone strobe phase.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count (entry to BUS)
//   en       : a BUS cycle is in progress
//   expired  : the current BUS cycle is the TIMEOUT-th one without termination
// With TIMEOUT = 0 the timer is removed and expired is tied low.
module wb_timeout_cnt
  import cpu_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, clr, en};
    assign expired    = 1'b0;
  end else begin : g_cnt
    localparam int unsigned CW = cnt_width(TIMEOUT);
    // cnt holds the number of BUS cycles already completed, so the cycle in
    // which cnt == TIMEOUT-1 is the last one STB may stay high.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt <= '0;
      end else if (en && (cnt != LAST)) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign expired = en && (cnt == LAST);
  end

endmodule

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: Wishbone classic-cycle master driven by a valid/ready CPU
// request port.
//   clk, rst           : clock, synchronous active-high reset
//   req_*              : CPU request (valid/ready handshake, we, addr, wdata,
//                        sel with 0 = all lanes, last = release CYC afterwards)
//   rsp_*              : one-cycle completion pulse with read data, error and
//                        timeout flags
//   wb_*               : Wishbone master signals
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no cycle open, CYC=0 STB=0, ready for a request
//   BUS   | beat in flight, CYC=1 STB=1, waiting for ACK/ERR/timeout
//   HOLD  | block transfer open, CYC=1 STB=0, waiting for the next beat
module wb_master_bridge
  import cpu_wb_pkg::*;
#(
  parameter  int unsigned AW      = 16,
  parameter  int unsigned DW      = 16,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned SEL_W   = DW / 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_last,

  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_timeout,

  output logic [AW-1:0]    wb_adr_o,
  output logic [DW-1:0]    wb_dat_o,
  input  logic [DW-1:0]    wb_dat_i,
  output logic             wb_we_o,
  output logic [SEL_W-1:0] wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  wb_state_t       state, state_n;
  wb_req_t         req_q, req_n;
  logic            stb_q, stb_n;
  logic            cyc_q, cyc_n;
  logic            rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic [DW-1:0]   rsp_rdata_n;
  logic            accept;
  logic            tmo_expired;
  logic            unused_req_hi;

  assign req_ready = (state != BUS) && !rst;
  assign accept    = req_valid && req_ready;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == BUS),
    .expired (tmo_expired)
  );

  always_comb begin
    state_n       = state;
    req_n         = req_q;
    stb_n         = stb_q;
    cyc_n         = cyc_q;
    rsp_valid_n   = 1'b0;
    rsp_err_n     = 1'b0;
    rsp_timeout_n = 1'b0;
    rsp_rdata_n   = '0;

    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          req_n                  = '0;
          req_n.we               = req_we;
          req_n.addr[AW-1:0]     = req_addr;
          req_n.wdata[DW-1:0]    = req_wdata;
          req_n.sel[SEL_W-1:0]   = (req_sel == '0) ? {SEL_W{1'b1}} : req_sel;
          req_n.last             = req_last;
          stb_n                  = 1'b1;
          cyc_n                  = 1'b1;
          state_n                = BUS;
        end
      end

      BUS: begin
        // ERR beats ACK; a real ACK beats a timeout landing in the same cycle.
        if (wb_err_i || (!wb_ack_i && tmo_expired)) begin
          state_n       = IDLE;
          req_n         = '0;
          stb_n         = 1'b0;
          cyc_n         = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = !wb_err_i;
        end else if (wb_ack_i) begin
          stb_n       = 1'b0;
          rsp_valid_n = 1'b1;
          if (!req_q.we) begin
            rsp_rdata_n = wb_dat_i;
          end
          if (req_q.last) begin
            state_n = IDLE;
            req_n   = '0;
            cyc_n   = 1'b0;
          end else begin
            state_n = HOLD;
          end
        end
      end

      default: begin
        state_n = IDLE;
        req_n   = '0;
        stb_n   = 1'b0;
        cyc_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_n;
      req_q       <= req_n;
      stb_q       <= stb_n;
      cyc_q       <= cyc_n;
      rsp_valid   <= rsp_valid_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
      rsp_rdata   <= rsp_rdata_n;
    end
  end

  assign wb_adr_o = req_q.addr[AW-1:0];
  assign wb_dat_o = req_q.wdata[DW-1:0];
  assign wb_we_o  = req_q.we;
  assign wb_sel_o = req_q.sel[SEL_W-1:0];
  assign wb_stb_o = stb_q;
  assign wb_cyc_o = cyc_q;

  // Upper struct bits beyond this instance's widths are always zero.
  assign unused_req_hi = ^(req_q.addr >> AW) ^ ^(req_q.wdata >> DW) ^ ^(req_q.sel >> SEL_W);

endmodule

// File: tb/tb_wb_master_bridge.sv
module tb_wb_master_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: 16-bit data, TIMEOUT = 4
  logic        a_req_valid, a_req_ready, a_req_we, a_req_last;
  logic [15:0] a_req_addr, a_req_wdata;
  logic [1:0]  a_req_sel;
  logic        a_rsp_valid, a_rsp_err, a_rsp_timeout;
  logic [15:0] a_rsp_rdata;
  logic [15:0] a_adr, a_dat_o, a_dat_i;
  logic        a_we, a_stb, a_cyc, a_ack, a_err;
  logic [1:0]  a_sel;

  // Instance B: 32-bit data, timeout disabled
  logic        b_req_valid, b_req_ready, b_req_we, b_req_last;
  logic [15:0] b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_sel;
  logic        b_rsp_valid, b_rsp_err, b_rsp_timeout;
  logic [31:0] b_rsp_rdata;
  logic [15:0] b_adr;
  logic [31:0] b_dat_o, b_dat_i;
  logic        b_we, b_stb, b_cyc, b_ack, b_err;
  logic [3:0]  b_sel;

  wb_master_bridge #(.AW(16), .DW(16), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_sel(a_req_sel),
    .req_last(a_req_last),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .rsp_timeout(a_rsp_timeout),
    .wb_adr_o(a_adr), .wb_dat_o(a_dat_o), .wb_dat_i(a_dat_i), .wb_we_o(a_we),
    .wb_sel_o(a_sel), .wb_stb_o(a_stb), .wb_cyc_o(a_cyc),
    .wb_ack_i(a_ack), .wb_err_i(a_err)
  );

  wb_master_bridge #(.AW(16), .DW(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_sel(b_req_sel),
    .req_last(b_req_last),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .rsp_timeout(b_rsp_timeout),
    .wb_adr_o(b_adr), .wb_dat_o(b_dat_o), .wb_dat_i(b_dat_i), .wb_we_o(b_we),
    .wb_sel_o(b_sel), .wb_stb_o(b_stb), .wb_cyc_o(b_cyc),
    .wb_ack_i(b_ack), .wb_err_i(b_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One beat on instance A, entered and left on a falling edge.
  // kind: 0 = ACK, 1 = ERR, 2 = ERR+ACK together, 3 = slave silent (timeout)
  task automatic beat_a(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] sel, input bit last, input int waits,
                        input int kind, input logic [15:0] sdata, input bit in_seq,
                        output bit seq_after);
    logic [1:0]  exp_sel;
    logic [15:0] exp_rdata;
    int          n;
    exp_sel   = (sel == 2'b00) ? 2'b11 : sel;
    exp_rdata = (kind == 0 && !we) ? sdata : 16'h0;

    check("ready_before", a_req_ready, 1);
    check("cyc_before", a_cyc, in_seq);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_sel   = sel;
    a_req_last  = last;
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_addr  = 16'($urandom);
    a_req_wdata = 16'($urandom);
    a_req_sel   = 2'($urandom);
    check("stb_on", a_stb, 1);
    check("cyc_on", a_cyc, 1);
    check("ready_bus", a_req_ready, 0);
    check("adr", a_adr, addr);
    check("dat_o", a_dat_o, wdata);
    check("we", a_we, we);
    check("sel", a_sel, exp_sel);

    if (kind == 3) begin
      n = 0;
      while (a_stb === 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("tmo_stb_cycles", n, 4);
    end else begin
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        check("stb_wait", a_stb, 1);
        check("adr_hold", a_adr, addr);
        check("rsp_wait", a_rsp_valid, 0);
      end
      a_ack   = (kind == 0 || kind == 2);
      a_err   = (kind == 1 || kind == 2);
      a_dat_i = sdata;
      @(negedge clk);
      a_ack   = 1'b0;
      a_err   = 1'b0;
      a_dat_i = 16'($urandom);
    end

    check("rsp_valid", a_rsp_valid, 1);
    check("rsp_rdata", a_rsp_rdata, exp_rdata);
    check("rsp_err", a_rsp_err, kind != 0);
    check("rsp_timeout", a_rsp_timeout, kind == 3);
    check("stb_after", a_stb, 0);
    seq_after = (kind == 0) && !last;
    check("cyc_after", a_cyc, seq_after);
    if (!seq_after) begin
      check("adr_zero", a_adr, 0);
      check("sel_zero", a_sel, 0);
    end
    check("ready_after", a_req_ready, 1);
  endtask

  task automatic idle_a(input int cycles, input bit seq);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("gap_cyc", a_cyc, seq);
      check("gap_stb", a_stb, 0);
      check("gap_rsp", a_rsp_valid, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit seq;
  int n;
  int r;

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_req_sel = '0; a_req_last = 1'b1; a_dat_i = '0; a_ack = 1'b0; a_err = 1'b0;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_req_sel = '0; b_req_last = 1'b1; b_dat_i = '0; b_ack = 1'b0; b_err = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state (a request is pending, yet nothing may be accepted)
    check("rst_ready_a", a_req_ready, 0);
    check("rst_ready_b", b_req_ready, 0);
    check("rst_cyc", a_cyc, 0);
    check("rst_stb", a_stb, 0);
    check("rst_we", a_we, 0);
    check("rst_adr", a_adr, 0);
    check("rst_dat", a_dat_o, 0);
    check("rst_sel", a_sel, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_rdata", a_rsp_rdata, 0);
    check("rst_rsp_err", a_rsp_err, 0);
    check("rst_rsp_tmo", a_rsp_timeout, 0);
    check("rst_cyc_b", b_cyc, 0);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single read, zero-wait slave
    beat_a(1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 0, 0, 16'hBEEF, 1'b0, seq);
    idle_a(2, seq);

    // Block write of three beats with two wait states each
    seq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_a(1'b1, 16'h0100 + 16'(i * 2), 16'($urandom), 2'b11, i == 2, 2, 0,
             16'h5A5A, seq, seq);
    end
    idle_a(1, seq);

    // ERR together with ACK on a read
    beat_a(1'b0, 16'h0200, 16'h0000, 2'b01, 1'b1, 1, 2, 16'h1234, 1'b0, seq);
    idle_a(1, seq);

    // ERR on the first beat of an open block
    beat_a(1'b1, 16'h0300, 16'hA5A5, 2'b10, 1'b0, 0, 1, 16'h0000, 1'b0, seq);
    idle_a(1, seq);

    // Silent slave, TIMEOUT = 4
    beat_a(1'b0, 16'h0400, 16'h0000, 2'b00, 1'b1, 0, 3, 16'h0000, 1'b0, seq);
    idle_a(1, seq);

    // Instance B: default lane select and a 1000-cycle stall without timeout
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h1234;
    b_req_wdata = 32'hCAFE_F00D; b_req_sel = 4'h0; b_req_last = 1'b1;
    check("b_ready", b_req_ready, 1);
    @(negedge clk);
    b_req_valid = 1'b0; b_req_sel = 4'h3; b_req_wdata = 32'h0;
    check("b_sel_all", b_sel, 4'hF);
    check("b_adr", b_adr, 16'h1234);
    check("b_dat", b_dat_o, 32'hCAFE_F00D);
    check("b_stb", b_stb, 1);
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (b_stb === 1'b1 && b_rsp_valid === 1'b0) n++;
    end
    check("b_stall_cycles", n, 1000);
    check("b_ready_bus", b_req_ready, 0);
    b_err = 1'b1;
    @(negedge clk);
    b_err = 1'b0;
    check("b_rsp_valid", b_rsp_valid, 1);
    check("b_rsp_err", b_rsp_err, 1);
    check("b_rsp_tmo", b_rsp_timeout, 0);
    check("b_rsp_rdata", b_rsp_rdata, 0);
    check("b_cyc_after", b_cyc, 0);
    check("b_sel_zero", b_sel, 0);

    // Reset while a beat is on the bus, then a late ACK
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0777;
    a_req_wdata = 16'h4321; a_req_sel = 2'b01; a_req_last = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("mid_stb", a_stb, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cyc", a_cyc, 0);
    check("mid_rst_stb", a_stb, 0);
    check("mid_rst_adr", a_adr, 0);
    check("mid_rst_dat", a_dat_o, 0);
    check("mid_rst_we", a_we, 0);
    check("mid_rst_sel", a_sel, 0);
    check("mid_rst_rsp", a_rsp_valid, 0);
    check("mid_rst_ready", a_req_ready, 0);
    rst = 1'b0;
    a_ack = 1'b1;
    a_dat_i = 16'hDEAD;
    @(negedge clk);
    a_ack = 1'b0;
    check("late_ack_rsp", a_rsp_valid, 0);
    check("late_ack_cyc", a_cyc, 0);
    @(negedge clk);
    check("late_ack_rsp2", a_rsp_valid, 0);
    check("late_ack_rdata", a_rsp_rdata, 0);

    // Randomised beats against the transaction-level expectations in beat_a
    seq = 1'b0;
    repeat (60) begin
      r = $urandom_range(0, 9);
      beat_a(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 2),
             (r <= 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : 3,
             16'($urandom), seq, seq);
      idle_a($urandom_range(0, 2), seq);
    end
    if (seq) begin
      beat_a(1'b0, 16'h0ABC, 16'h0, 2'b00, 1'b1, 0, 0, 16'h7E57, seq, seq);
    end
    idle_a(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
